// File: rtl/matrix_engine_pkg.sv
// Shared constants and the state encoding of the element-wise matrix engine.
package matrix_engine_pkg;

    localparam int RESULT_ID = 7;
    localparam int HDR_WORDS = 3;

    typedef enum logic [3:0] {
        IDLE,
        HDR_A,
        HDR_B,
        CHECK,
        RD_A,
        RD_B,
        WRITE,
        WR_HDR,
        FINISH,
        FAIL
    } engine_state_t;

endpackage

// File: rtl/matrix_op_selector_pkg.sv
// Operation codes produced by the upstream operation selector and consumed
// by the matrix engines.
package matrix_op_selector_pkg;

    typedef enum logic [2:0] {
        CALC_NONE       = 3'd0,
        CALC_ADD        = 3'd1,
        CALC_SUB        = 3'd2,
        CALC_MUL        = 3'd3,
        CALC_SCALAR_MUL = 3'd4,
        CALC_TRANSPOSE  = 3'd5,
        CALC_DET        = 3'd6,
        CALC_INV        = 3'd7
    } calc_type_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over a rows x cols matrix, with a flag that
// marks the final element.
module matrix_index_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] rows,
    input  logic [7:0] cols,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic       col_wrap;

    assign col_wrap = (col_q == cols - 8'd1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = 8'd0;
            col_d = 8'd0;
        end else if (advance) begin
            if (col_wrap) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 8'd0;
            col_q <= 8'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = col_wrap && (row_q == rows - 8'd1);

endmodule

// File: rtl/matrix_elemwise_engine.sv
// Element-wise matrix engine: ADD, SCALAR_MUL and TRANSPOSE over matrix
// blocks stored in a shared single-port BRAM, result written to RESULT_ID.
module matrix_elemwise_engine
    import matrix_op_selector_pkg::*;
    import matrix_engine_pkg::*;
#(
    parameter int BLOCK_SIZE = 1152,
    parameter int ADDR_WIDTH = 14,
    parameter int RESULT_ID  = matrix_engine_pkg::RESULT_ID
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  calc_type_t            op_type,
    input  logic [2:0]            mat_a_id,
    input  logic [2:0]            mat_b_id,
    input  logic [31:0]           scalar,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_wr_en,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0]            RES_ID   = 3'(RESULT_ID);
    localparam logic [ADDR_WIDTH-1:0] HDR_OFS  = ADDR_WIDTH'(HDR_WORDS);
    localparam logic [15:0]           MAX_ELEM = 16'(BLOCK_SIZE - HDR_WORDS);

    engine_state_t state_q, state_d;
    calc_type_t    op_q, op_d;
    logic [2:0]    a_id_q, a_id_d, b_id_q, b_id_d;
    logic [31:0]   scalar_q, scalar_d;
    logic [7:0]    rows_q, rows_d, cols_q, cols_d;
    logic [15:0]   a_hdr_q, a_hdr_d;
    logic [31:0]   a_val_q, a_val_d;
    logic          error_q, error_d;

    logic          cnt_clear, cnt_advance, cnt_last;
    logic [7:0]    row, col;

    logic [ADDR_WIDTH-1:0] a_base, b_base, r_base;
    logic [15:0]           elem_off, trans_off;
    logic [15:0]           hdr_a, chk_elems;
    logic                  chk_bad;

    matrix_index_counter u_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .rows    (rows_q),
        .cols    (cols_q),
        .row     (row),
        .col     (col),
        .last    (cnt_last)
    );

    assign a_base    = ADDR_WIDTH'(32'(a_id_q) * BLOCK_SIZE);
    assign b_base    = ADDR_WIDTH'(32'(b_id_q) * BLOCK_SIZE);
    assign r_base    = ADDR_WIDTH'(RESULT_ID * BLOCK_SIZE);
    assign elem_off  = {8'd0, row} * {8'd0, cols_q} + {8'd0, col};
    assign trans_off = {8'd0, col} * {8'd0, rows_q} + {8'd0, row};

    // For ADD the A header was captured a cycle earlier; otherwise it is on dout now.
    assign hdr_a     = (op_q == CALC_ADD) ? a_hdr_q : bram_dout[31:16];
    assign chk_elems = {8'd0, hdr_a[15:8]} * {8'd0, hdr_a[7:0]};
    assign chk_bad   = (hdr_a[15:8] == 8'd0) || (hdr_a[7:0] == 8'd0) ||
                       (chk_elems > MAX_ELEM) ||
                       ((op_q == CALC_ADD) && (bram_dout[31:16] != hdr_a));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_id_d      = a_id_q;
        b_id_d      = b_id_q;
        scalar_d    = scalar_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        a_hdr_d     = a_hdr_q;
        a_val_d     = a_val_q;
        error_d     = error_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        bram_addr   = '0;
        bram_wr_en  = 1'b0;
        bram_din    = 32'd0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d     = op_type;
                    a_id_d   = mat_a_id;
                    b_id_d   = mat_b_id;
                    scalar_d = scalar;
                    error_d  = 1'b0;
                    if (!(op_type inside {CALC_ADD, CALC_SCALAR_MUL, CALC_TRANSPOSE}) ||
                        (mat_a_id == RES_ID) || (mat_b_id == RES_ID))
                        state_d = FAIL;
                    else
                        state_d = HDR_A;
                end
            end
            HDR_A: begin
                bram_addr = a_base;
                state_d   = (op_q == CALC_ADD) ? HDR_B : CHECK;
            end
            HDR_B: begin
                bram_addr = b_base;
                a_hdr_d   = bram_dout[31:16];
                state_d   = CHECK;
            end
            CHECK: begin
                rows_d    = hdr_a[15:8];
                cols_d    = hdr_a[7:0];
                cnt_clear = 1'b1;
                state_d   = chk_bad ? FAIL : RD_A;
            end
            RD_A: begin
                bram_addr = a_base + HDR_OFS + ADDR_WIDTH'(elem_off);
                state_d   = (op_q == CALC_ADD) ? RD_B : WRITE;
            end
            RD_B: begin
                bram_addr = b_base + HDR_OFS + ADDR_WIDTH'(elem_off);
                a_val_d   = bram_dout;
                state_d   = WRITE;
            end
            WRITE: begin
                bram_wr_en = 1'b1;
                bram_addr  = r_base + HDR_OFS +
                             ADDR_WIDTH'((op_q == CALC_TRANSPOSE) ? trans_off : elem_off);
                if (op_q == CALC_ADD)
                    bram_din = a_val_q + bram_dout;
                else if (op_q == CALC_SCALAR_MUL)
                    bram_din = bram_dout * scalar_q;
                else
                    bram_din = bram_dout;
                if (cnt_last) begin
                    state_d = WR_HDR;
                end else begin
                    cnt_advance = 1'b1;
                    state_d     = RD_A;
                end
            end
            WR_HDR: begin
                bram_wr_en = 1'b1;
                bram_addr  = r_base;
                bram_din   = (op_q == CALC_TRANSPOSE) ? {cols_q, rows_q, 16'd0}
                                                      : {rows_q, cols_q, 16'd0};
                state_d    = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FAIL: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == FAIL)
            error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= CALC_NONE;
            a_id_q   <= 3'd0;
            b_id_q   <= 3'd0;
            scalar_q <= 32'd0;
            rows_q   <= 8'd0;
            cols_q   <= 8'd0;
            a_hdr_q  <= 16'd0;
            a_val_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_id_q   <= a_id_d;
            b_id_q   <= b_id_d;
            scalar_q <= scalar_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            a_hdr_q  <= a_hdr_d;
            a_val_q  <= a_val_d;
            error_q  <= error_d;
        end
    end

    assign op_ready = (state_q == IDLE);
    assign busy     = !(state_q inside {IDLE, FINISH, FAIL});
    assign error    = error_q;

endmodule

// File: tb/tb_matrix_elemwise_engine.sv
// Scoreboard bench for matrix_elemwise_engine: a behavioural BRAM plus a
// matrix-level reference model feeding an expectation queue.
module tb_matrix_elemwise_engine;
    import matrix_op_selector_pkg::*;

    localparam int BS  = 1152;
    localparam int AW  = 14;
    localparam int RID = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    calc_type_t    op_type;
    logic [2:0]    mat_a_id, mat_b_id;
    logic [31:0]   scalar;
    logic [AW-1:0] bram_addr;
    logic          bram_wr_en;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout;
    logic          busy, done, error;

    always #5 clk = ~clk;

    matrix_elemwise_engine #(.BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .RESULT_ID(RID)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_type(op_type), .mat_a_id(mat_a_id), .mat_b_id(mat_b_id), .scalar(scalar),
        .bram_addr(bram_addr), .bram_wr_en(bram_wr_en), .bram_din(bram_din),
        .bram_dout(bram_dout), .busy(busy), .done(done), .error(error)
    );

    // Behavioural BRAM with a bench-side preload port.
    logic [31:0]   mem [0:16383];
    logic [31:0]   rd_q;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    assign bram_dout = rd_q;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bram_wr_en) mem[bram_addr] <= bram_din;
        rd_q <= mem[bram_addr];
    end

    int errors = 0;
    int checks = 0;

    typedef struct { bit err; int n; } exp_t;
    typedef struct { int off; logic [31:0] data; } word_t;
    exp_t  exp_q[$];
    word_t word_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic poke(int addr, logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = AW'(addr);
        pl_data = data;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Fills a block; seq_start >= 0 gives sequential data, otherwise random.
    task automatic fill_block(int id, int r, int c, int seq_start);
        poke(id * BS, {8'(r), 8'(c), 16'd0});
        if (r * c <= BS - 3)
            for (int k = 0; k < r * c; k++)
                poke(id * BS + 3 + k, (seq_start >= 0) ? 32'(seq_start + k) : $urandom);
    endtask

    // Reference model: works from matrix semantics on the bench's memory image.
    task automatic model_push(calc_type_t op, int a, int b, logic [31:0] s);
        exp_t e;
        int ra, ca, rb, cb;
        logic [31:0] av, bv, res;
        longint prod;
        ra = int'(mem[a * BS][31:24]); ca = int'(mem[a * BS][23:16]);
        rb = int'(mem[b * BS][31:24]); cb = int'(mem[b * BS][23:16]);
        e.err = !(op == CALC_ADD || op == CALC_SCALAR_MUL || op == CALC_TRANSPOSE) ||
                a == RID || b == RID;
        if (!e.err)
            e.err = ra == 0 || ca == 0 || ra * ca > BS - 3 ||
                    (op == CALC_ADD && (ra != rb || ca != cb));
        e.n = 0;
        if (!e.err) begin
            for (int i = 0; i < ra; i++)
                for (int j = 0; j < ca; j++) begin
                    word_t w;
                    av = mem[a * BS + 3 + i * ca + j];
                    bv = mem[b * BS + 3 + i * ca + j];
                    prod = longint'($signed(av)) * longint'($signed(s));
                    case (op)
                        CALC_ADD:        res = av + bv;
                        CALC_SCALAR_MUL: res = prod[31:0];
                        default:         res = av;
                    endcase
                    w.off  = (op == CALC_TRANSPOSE) ? 3 + j * ra + i : 3 + i * ca + j;
                    w.data = res;
                    word_q.push_back(w);
                    e.n++;
                end
            begin
                word_t h;
                h.off  = 0;
                h.data = (op == CALC_TRANSPOSE) ? {8'(ca), 8'(ra), 16'd0}
                                                : {8'(ra), 8'(ca), 16'd0};
                word_q.push_back(h);
                e.n++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: tracks accepted requests and scores each completion.
    bit in_txn = 0;
    int wr_cnt = 0;
    bit prev_done = 0;

    task automatic finish_txn();
        exp_t e;
        word_t w;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got completion done=%0d error=%0d, want none", done, error);
            return;
        end
        e = exp_q.pop_front();
        chk("done_vs_model", {31'd0, done}, {31'd0, !e.err});
        chk("error_vs_model", {31'd0, error}, {31'd0, e.err});
        if (error) chk("no_writes_on_fail", wr_cnt, 0);
        for (int k = 0; k < e.n; k++) begin
            w = word_q.pop_front();
            if (done) chk($sformatf("result_off%0d", w.off), mem[RID * BS + w.off], w.data);
        end
        if (done && !e.err) chk("write_count", wr_cnt, e.n);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 0; wr_cnt = 0; prev_done = 0;
        end else begin
            if (prev_done) chk("done_single_pulse", {31'd0, done}, 32'd0);
            prev_done = done;
            if (bram_wr_en) begin
                wr_cnt++;
                chk("wr_in_result_block",
                    {31'd0, (int'(bram_addr) >= RID * BS) && (int'(bram_addr) < (RID + 1) * BS)}, 32'd1);
            end
            if (in_txn && (done || error)) begin
                finish_txn();
                in_txn = 0;
            end
            if (op_valid && op_ready) begin
                in_txn = 1; wr_cnt = 0;
            end
        end
    end

    task automatic issue(calc_type_t op, int a, int b, logic [31:0] s, bit push);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!op_ready && n < 3000);
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got op_ready=0, want 1");
            return;
        end
        if (push) model_push(op, a, b, s);
        op_valid = 1'b1; op_type = op;
        mat_a_id = 3'(a); mat_b_id = 3'(b); scalar = s;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_type  = calc_type_t'($urandom_range(0, 7));
        mat_a_id = 3'($urandom); mat_b_id = 3'($urandom); scalar = $urandom;
    endtask

    task automatic wait_end();
        int n = 0;
        @(negedge clk);
        while (!(done || error) && n < 3000) begin @(negedge clk); n++; end
        if (!(done || error)) begin
            checks++; errors++;
            $display("FAIL completion_timeout: got done=0 error=0, want one of them");
        end
    endtask

    task automatic pester();
        repeat (3) @(negedge clk);
        op_valid = 1'b1; op_type = CALC_SCALAR_MUL; mat_a_id = 3'd4; mat_b_id = 3'd5;
        @(negedge clk);
        chk("op_ready_low_while_busy", {31'd0, op_ready}, 32'd0);
        chk("busy_high", {31'd0, busy}, 32'd1);
        op_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_op_ready"}, {31'd0, op_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, bram_wr_en}, 32'd0);
        chk({tag, "_addr"}, 32'(bram_addr), 32'd0);
        chk({tag, "_din"}, bram_din, 32'd0);
    endtask

    int dims_r[10] = '{3, 3, 2, 4, 0, 3, 1, 5, 8, 35};
    int dims_c[10] = '{3, 3, 4, 2, 3, 0, 1, 6, 8, 35};

    initial begin
        int n, k, a, b, op_sel;
        calc_type_t op;
        rst_n = 1'b0; op_valid = 1'b0; op_type = CALC_NONE;
        mat_a_id = 3'd0; mat_b_id = 3'd0; scalar = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        fill_block(0, 3, 3, 0);
        fill_block(1, 3, 3, 10);
        fill_block(2, 4, 4, 20);
        fill_block(3, 3, 4, 40);

        fork
            begin issue(CALC_ADD, 0, 1, 32'd0, 1); wait_end(); end
            begin @(posedge op_valid); @(negedge op_valid); pester(); end
        join
        issue(CALC_SCALAR_MUL, 2, 0, -32'sd3, 1); wait_end();
        issue(CALC_TRANSPOSE, 3, 0, 32'd0, 1);    wait_end();
        issue(CALC_ADD, 0, 2, 32'd0, 1);          wait_end();

        issue(CALC_MUL, 0, 1, 32'd0, 1);
        @(negedge clk);
        chk("mul_error_next_cycle", {31'd0, error}, 32'd1);
        chk("mul_no_wr", {31'd0, bram_wr_en}, 32'd0);
        chk("mul_no_addr", 32'(bram_addr), 32'd0);
        issue(CALC_ADD, 0, 1, 32'd0, 1);
        @(negedge clk);
        chk("error_cleared_by_accept", {31'd0, error}, 32'd0);
        wait_end();
        issue(CALC_ADD, 7, 1, 32'd0, 1); wait_end();

        // Abort mid-operation after the 4th element write.
        poke(RID * BS + 7, 32'hDEAD_BEEF);
        issue(CALC_SCALAR_MUL, 2, 0, 32'd5, 0);
        n = 0; k = 0;
        while (k < 4 && n < 500) begin
            @(negedge clk); n++;
            if (bram_wr_en) k++;
        end
        chk("abort_saw_4_writes", k, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_wr_in_reset", {31'd0, bram_wr_en}, 32'd0);
        end
        chk("abort_elem4_untouched", mem[RID * BS + 7], 32'hDEAD_BEEF);
        chk("abort_elem3_written", mem[RID * BS + 6], 32'(5 * 23));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 40; t++) begin
            if (t % 10 == 0)
                for (int id = 0; id < 7; id++) begin
                    k = $urandom_range(0, 9);
                    fill_block(id, dims_r[k], dims_c[k], -1);
                end
            op_sel = $urandom_range(0, 6);
            op = (op_sel < 3) ? CALC_ADD : (op_sel == 3) ? CALC_SCALAR_MUL :
                 (op_sel == 4) ? CALC_TRANSPOSE : (op_sel == 5) ? CALC_MUL : CALC_NONE;
            a = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
            b = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
            issue(op, a, b, $urandom, 1);
            wait_end();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_elemwise_engine.md
MATRIX_ELEMWISE_ENGINE -- requirements
Module: matrix_elemwise_engine

Interface
REQ-001 Parameters SHALL be: BLOCK_SIZE, default 1152, words per matrix block; ADDR_WIDTH, default 14, BRAM address width; RESULT_ID, default 7, block that receives the result.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 op_valid  in  1  operation request, carrying the result fields of the upstream operation selector.
REQ-005 op_ready  out  1  high only in IDLE; a request is accepted on a cycle where op_valid and op_ready are both high.
REQ-006 op_type  in  calc_type_t  requested operation.
REQ-007 mat_a_id  in  3  ID of matrix A.
REQ-008 mat_b_id  in  3  ID of matrix B.
REQ-009 scalar  in  32  signed scalar operand.
REQ-010 bram_addr  out  ADDR_WIDTH  address on the shared BRAM port.
REQ-011 bram_wr_en  out  1  write strobe.
REQ-012 bram_din  out  32  write data.
REQ-013 bram_dout  in  32  read data, valid one cycle after the address is presented.
REQ-014 busy  out  1  high from acceptance until done or error.
REQ-015 done  out  1  one-cycle pulse on successful completion.
REQ-016 error  out  1  level; set on failure, cleared on the next accepted request.

Function
REQ-017 Block layout SHALL be: base = id*BLOCK_SIZE; header word at base = {rows[31:24], cols[23:16], 16'd0}; element (i,j) at base+3+i*cols+j.
REQ-018 Supported ops SHALL be CALC_ADD (A+B), CALC_SCALAR_MUL (A*scalar) and CALC_TRANSPOSE (A^T); any other op_type SHALL set error one cycle after acceptance, with no BRAM access.
REQ-019 FSM states SHALL be: IDLE, HDR_A, HDR_B, CHECK, RD_A, RD_B, WRITE, WR_HDR, FINISH, FAIL.
REQ-020 The header of B SHALL be read only for CALC_ADD.
REQ-021 CHECK SHALL go to FAIL when any of the following holds: rows==0; cols==0; rows*cols > BLOCK_SIZE-3; for CALC_ADD, B's dimensions differ from A's.
REQ-022 The element loop SHALL run row-major over i<rows, j<cols, one element per RD_A[,RD_B],WRITE sequence, with at most one BRAM access per cycle.
REQ-023 The column counter SHALL wrap to 0 and increment the row counter; the loop SHALL end after the last element, element (rows-1, cols-1).
REQ-024 ADD SHALL compute a 32-bit two's-complement wrap sum.
REQ-025 SCALAR_MUL SHALL compute the low 32 bits of the signed product.
REQ-026 TRANSPOSE SHALL write A(i,j) to result offset 3+j*rows+i.
REQ-027 WR_HDR SHALL write {rows,cols,16'd0} for ADD and SCALAR_MUL, and {cols,rows,16'd0} for TRANSPOSE, after all elements are written.
REQ-028 FINISH SHALL pulse done for one cycle, then return to IDLE.
REQ-029 FAIL SHALL set error, perform no further writes, then return to IDLE.
REQ-030 On a FAIL path, the result block SHALL remain untouched.
REQ-031 When RESULT_ID equals mat_a_id or mat_b_id, the request SHALL go to FAIL.
REQ-032 op_valid while busy SHALL be ignored; op_ready stays low.
REQ-033 bram_wr_en SHALL be high only in WRITE and WR_HDR.
REQ-034 Inputs SHALL be latched at acceptance; later input changes SHALL have no effect on the running operation.

Reset
REQ-035 Reset SHALL force state IDLE, with op_ready=1, busy=0, done=0, error=0, bram_wr_en=0, bram_addr=0, bram_din=0, and all counters at 0.
REQ-036 Reset asserted mid-operation SHALL abort the operation within the reset; no write SHALL occur after rst_n falls.

Structure
REQ-037 calc_type_t SHALL be reused from matrix_op_selector_pkg.
REQ-038 The engine state enum and the RESULT_ID and HDR_WORDS=3 constants SHALL live in a shared matrix_engine_pkg.
REQ-039 One sub-module, matrix_index_counter, SHALL hold the row/col counters with wrap and last-element flag.
REQ-040 Address and arithmetic logic SHALL stay in the top level.

Verification
REQ-041 ADD: block 0 is 3x3 holding 0..8, block 1 is 3x3 holding 10..18; request ids 0,1 -> block 7 data is 10,12,...,26; header 0x03030000; single done pulse.
REQ-042 SCALAR_MUL: block 2 is 4x4 holding 20..35; scalar=-3 -> block 7 holds -60..-105; header 0x04040000.
REQ-043 TRANSPOSE: block 3 is 3x4 holding 40..51 -> block 7 holds 40,44,48,41,45,49,...,51; header 0x04030000.
REQ-044 ADD on 0 (3x3) + 2 (4x4) -> error=1, done never pulses, zero writes observed.
REQ-045 CALC_MUL request -> error=1 the next cycle with no BRAM access; the next valid ADD request clears error.
REQ-046 Robustness: op_valid pulsed while busy changes nothing; rst_n asserted after the 4th element write -> no further wr_en, all outputs at reset values.
